// File: rtl/rbb_pingpong_if.sv
// rtl/rbb_pingpong_if.sv - PE write side and host drain side of the result batch buffer
interface rbb_pingpong_if #(
    parameter int WR_DATA_WIDTH   = 32,
    parameter int WORDS_PER_LINE  = 16,
    parameter int LINE_ADDR_WIDTH = 8,
    parameter int LINE_WIDTH      = WR_DATA_WIDTH * WORDS_PER_LINE
);
    logic                       wr_valid;
    logic [WR_DATA_WIDTH-1:0]   wr_data;
    logic                       task_done;
    logic                       wr_ready;
    logic                       req_valid;
    logic [LINE_ADDR_WIDTH-1:0] req_line_idx;
    logic [LINE_WIDTH-1:0]      req_data;
    logic                       req_last;
    logic                       req_ack;
    logic [LINE_ADDR_WIDTH:0]   batch_lines;
    logic                       batch_done;
    logic                       full;
    logic                       empty;

    modport master (
        output wr_valid, wr_data, task_done, req_ack,
        input  wr_ready, req_valid, req_line_idx, req_data, req_last,
               batch_lines, batch_done, full, empty
    );

    modport slave (
        input  wr_valid, wr_data, task_done, req_ack,
        output wr_ready, req_valid, req_line_idx, req_data, req_last,
               batch_lines, batch_done, full, empty
    );
endinterface

// File: rtl/rbb_pingpong.sv
// rtl/rbb_pingpong.sv - double-buffered result batch buffer packing PE words into host lines
module rbb_pingpong #(
    parameter int WR_DATA_WIDTH   = 32,
    parameter int WORDS_PER_LINE  = 16,
    parameter int LINE_ADDR_WIDTH = 8,
    parameter int LINE_WIDTH      = WR_DATA_WIDTH * WORDS_PER_LINE
) (
    input logic           clk,
    input logic           reset_n,
    rbb_pingpong_if.slave bus
);
    localparam int WIDX  = $clog2(WORDS_PER_LINE);
    localparam int DEPTH = 1 << LINE_ADDR_WIDTH;
    localparam logic [WIDX-1:0] LAST_SLOT = WIDX'(WORDS_PER_LINE - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;

    // Fill side
    logic [WIDX-1:0]            wordIdx;
    logic [WIDX-1:0]            wordIdxNext;
    logic [LINE_ADDR_WIDTH:0]   lineCnt;
    logic [LINE_ADDR_WIDTH:0]   closeLines;
    logic [LINE_WIDTH-1:0]      lineBuf;
    logic [LINE_WIDTH-1:0]      lineNext;
    logic                       fillBank;
    logic                       padStall;

    // Per-bank state: busy from close until release, eligible once its last RAM write landed
    logic [1:0]                 bankBusy;
    logic [1:0]                 bankEligible;
    logic [LINE_ADDR_WIDTH:0]   bankLines [2];

    // Registered RAM write port
    logic                       wrEn;
    logic                       wrBank;
    logic                       wrClose;
    logic [LINE_ADDR_WIDTH-1:0] wrAddr;
    logic [LINE_WIDTH-1:0]      wrLine;
    logic [LINE_ADDR_WIDTH:0]   wrCloseLines;

    // Drain side
    logic [1:0]                 state;
    logic                       drainBank;
    logic [LINE_ADDR_WIDTH-1:0] rdIdx;
    logic [LINE_ADDR_WIDTH:0]   batchLines;
    logic [LINE_WIDTH-1:0]      rdData;
    logic                       batchDone;

    logic capFull, baseReady, wordFire, doneFire, lineDone, padNeeded;
    logic lineWrite, emptyClose, closeFire, isLast, releaseFire;

    logic [LINE_WIDTH-1:0] mem0 [DEPTH];
    logic [LINE_WIDTH-1:0] mem1 [DEPTH];

    always_comb begin
        capFull     = lineCnt[LINE_ADDR_WIDTH];
        baseReady   = !padStall && !bankBusy[fillBank];
        wordFire    = bus.wr_valid && baseReady && !capFull;
        doneFire    = bus.task_done && baseReady;
        lineDone    = wordFire && (wordIdx == LAST_SLOT);
        wordIdxNext = wordFire ? wordIdx + WIDX'(1) : wordIdx;
        padNeeded   = doneFire && (wordIdxNext != '0);
        lineWrite   = lineDone || padNeeded;
        emptyClose  = doneFire && !lineWrite && (lineCnt == '0);
        closeFire   = doneFire && !emptyClose;
        closeLines  = lineCnt + {{LINE_ADDR_WIDTH{1'b0}}, lineWrite};
    end

    // Unwritten slots stay zero because lineBuf is cleared after every line write
    always_comb begin
        lineNext = lineBuf;
        for (int s = 0; s < WORDS_PER_LINE; s++) begin
            if (wordFire && (wordIdx == WIDX'(s))) begin
                lineNext[LINE_WIDTH-1-s*WR_DATA_WIDTH -: WR_DATA_WIDTH] = bus.wr_data;
            end
        end
    end

    always_comb begin
        isLast      = ({1'b0, rdIdx} == (batchLines - 1'b1));
        releaseFire = (state == ST_PRESENT) && bus.req_ack && isLast;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wordIdx      <= '0;
            lineCnt      <= '0;
            lineBuf      <= '0;
            fillBank     <= 1'b0;
            padStall     <= 1'b0;
            bankBusy     <= '0;
            bankEligible <= '0;
            bankLines[0] <= '0;
            bankLines[1] <= '0;
            wrEn         <= 1'b0;
            wrBank       <= 1'b0;
            wrClose      <= 1'b0;
            wrAddr       <= '0;
            wrLine       <= '0;
            wrCloseLines <= '0;
        end else begin
            wrEn         <= lineWrite;
            wrBank       <= fillBank;
            wrAddr       <= lineCnt[LINE_ADDR_WIDTH-1:0];
            wrLine       <= lineNext;
            wrClose      <= closeFire && lineWrite;
            wrCloseLines <= closeLines;
            padStall     <= padNeeded;

            if (closeFire) begin
                bankBusy[fillBank] <= 1'b1;
                fillBank           <= ~fillBank;
                lineCnt            <= '0;
                wordIdx            <= '0;
                lineBuf            <= '0;
                // With no line still in flight the bank can be drained right away
                if (!lineWrite) begin
                    bankEligible[fillBank] <= 1'b1;
                    bankLines[fillBank]    <= closeLines;
                end
            end else begin
                wordIdx <= wordIdxNext;
                lineBuf <= lineWrite ? '0 : lineNext;
                if (lineWrite) begin
                    lineCnt <= lineCnt + 1'b1;
                end
            end

            if (wrClose) begin
                bankEligible[wrBank] <= 1'b1;
                bankLines[wrBank]    <= wrCloseLines;
            end

            if (releaseFire) begin
                bankBusy[drainBank]     <= 1'b0;
                bankEligible[drainBank] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            if (wrBank) begin
                mem1[wrAddr] <= wrLine;
            end else begin
                mem0[wrAddr] <= wrLine;
            end
        end
    end

    // Banks close alternately, so draining alternates too and drainBank is always the oldest
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            drainBank  <= 1'b0;
            rdIdx      <= '0;
            batchLines <= '0;
            rdData     <= '0;
            batchDone  <= 1'b0;
        end else begin
            batchDone <= releaseFire || emptyClose;
            case (state)
                ST_IDLE: begin
                    if (bankEligible[drainBank]) begin
                        batchLines <= bankLines[drainBank];
                        rdIdx      <= '0;
                        state      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    rdData <= drainBank ? mem1[rdIdx] : mem0[rdIdx];
                    state  <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (bus.req_ack) begin
                        if (isLast) begin
                            rdIdx     <= '0;
                            drainBank <= ~drainBank;
                            state     <= ST_IDLE;
                        end else begin
                            rdIdx <= rdIdx + 1'b1;
                            state <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.wr_ready     = baseReady && (!capFull || bus.task_done);
    assign bus.req_valid    = (state == ST_PRESENT);
    assign bus.req_line_idx = rdIdx;
    assign bus.req_data     = rdData;
    assign bus.req_last     = (state == ST_PRESENT) && isLast;
    assign bus.batch_lines  = batchLines;
    assign bus.batch_done   = batchDone;
    assign bus.full         = &bankBusy;
    assign bus.empty        = ~|bankBusy && (lineCnt == '0) && (wordIdx == '0);
endmodule

// File: tb/tb_rbb_pingpong.sv
// tb/tb_rbb_pingpong.sv - directed self-checking bench for rbb_pingpong
module tb_rbb_pingpong;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rbb_pingpong_if bus ();
    rbb_pingpong dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    task automatic checkEq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [511:0] expLine(input int base, input int nWords, input int j);
        logic [511:0] l;
        l = '0;
        for (int s = 0; s < 16; s++) begin
            if (j * 16 + s < nWords) l[511-32*s -: 32] = 32'(base + j * 16 + s);
        end
        return l;
    endfunction

    task automatic sendWord(input logic [31:0] d, output int stalls);
        stalls = 0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        #1;
        while (!bus.wr_ready && stalls < 100) begin
            @(posedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 100) checkEq("wr_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        #1;
    endtask

    task automatic sendWords(input int base, input int n, output int stallSum);
        int st;
        stallSum = 0;
        for (int k = 0; k < n; k++) begin
            sendWord(32'(base + k), st);
            stallSum += st;
        end
    endtask

    task automatic sendDone(input logic withWord, input logic [31:0] d, output int stalls);
        stalls = 0;
        bus.task_done = 1'b1;
        bus.wr_valid  = withWord;
        bus.wr_data   = d;
        #1;
        while (!bus.wr_ready && stalls < 100) begin
            @(posedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 100) checkEq("done_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.task_done = 1'b0;
        bus.wr_valid  = 1'b0;
        #1;
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (!bus.req_valid && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) checkEq("req_valid_timeout", 0, 1);
    endtask

    task automatic ackLine(input int j, input int nLines, input logic [511:0] expData);
        int n;
        waitValid(n);
        checkEq("req_line_idx", 32'(bus.req_line_idx), 32'(j));
        checkEq("req_last", bus.req_last, (j == nLines - 1));
        checkEq("req_data", bus.req_data, expData);
        if (j == 0) checkEq("batch_lines", 32'(bus.batch_lines), 32'(nLines));
        bus.req_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.req_ack = 1'b0;
        #1;
        if (j == nLines - 1) checkEq("batch_done_pulse", bus.batch_done, 1);
    endtask

    task automatic drainBatch(input int base, input int nWords, input int nLines);
        for (int j = 0; j < nLines; j++) ackLine(j, nLines, expLine(base, nWords, j));
    endtask

    task automatic checkResetState(input string tag);
        checkEq({tag, "_wr_ready"}, bus.wr_ready, 1);
        checkEq({tag, "_empty"}, bus.empty, 1);
        checkEq({tag, "_req_valid"}, bus.req_valid, 0);
        checkEq({tag, "_req_last"}, bus.req_last, 0);
        checkEq({tag, "_batch_done"}, bus.batch_done, 0);
        checkEq({tag, "_full"}, bus.full, 0);
        checkEq({tag, "_req_line_idx"}, 32'(bus.req_line_idx), 0);
        checkEq({tag, "_batch_lines"}, 32'(bus.batch_lines), 0);
        checkEq({tag, "_req_data"}, bus.req_data, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        int n;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.task_done = 1'b0;
        bus.req_ack   = 1'b0;
        reset_n       = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        checkResetState("reset");

        // Single full line
        sendWords(0, 16, st);
        sendDone(1'b0, 0, st);
        waitValid(n);
        checkEq("t1_drain_latency", 32'(n), 2);
        ackLine(0, 1, expLine(0, 16, 0));
        checkEq("t1_empty", bus.empty, 1);
        step();
        checkEq("t1_done_low", bus.batch_done, 0);

        // Partial line
        sendWords(32'h40, 20, st);
        sendDone(1'b0, 0, st);
        checkEq("t2_pad_stall", bus.wr_ready, 0);
        step();
        checkEq("t2_pad_release", bus.wr_ready, 1);
        waitValid(n);
        checkEq("t2_drain_latency", 32'(n), 2);
        drainBatch(32'h40, 20, 2);

        // Ping-pong overlap
        sendWords(32'h100, 48, st);
        sendDone(1'b0, 0, st);
        waitValid(n);
        sendWords(32'h200, 32, st);
        sendDone(1'b0, 0, n);
        checkEq("t3_b_no_stall", 32'(st + n), 0);
        checkEq("t3_full", bus.full, 1);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'h300;
        #1;
        checkEq("t3_c_stall", bus.wr_ready, 0);
        ackLine(0, 3, expLine(32'h100, 48, 0));
        ackLine(1, 3, expLine(32'h100, 48, 1));
        waitValid(n);
        checkEq("t3_stall_before_release", bus.wr_ready, 0);
        ackLine(2, 3, expLine(32'h100, 48, 2));
        checkEq("t3_ready_after_release", bus.wr_ready, 1);
        sendWords(32'h300, 5, st);
        sendDone(1'b0, 0, st);
        drainBatch(32'h200, 32, 2);
        drainBatch(32'h300, 5, 1);

        // Bank overflow
        sendWords(0, 4096, st);
        checkEq("t4_no_stall", 32'(st), 0);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'h1000;
        #1;
        checkEq("t4_cap_stall0", bus.wr_ready, 0);
        step();
        checkEq("t4_cap_stall1", bus.wr_ready, 0);
        bus.wr_valid = 1'b0;
        sendDone(1'b0, 0, st);
        checkEq("t4_done_accept", 32'(st), 0);
        drainBatch(0, 4096, 256);

        // Empty batch, then word and done together
        sendDone(1'b0, 0, st);
        checkEq("t5_empty_done", bus.batch_done, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            checkEq("t5_no_drain", bus.req_valid, 0);
        end
        sendDone(1'b1, 32'hABCD, st);
        drainBatch(32'hABCD, 1, 1);

        // Reset mid-drain
        sendWords(32'h1000, 160, st);
        sendDone(1'b0, 0, st);
        for (int j = 0; j < 5; j++) ackLine(j, 10, expLine(32'h1000, 160, j));
        waitValid(n);
        checkEq("t6_at_idx5", 32'(bus.req_line_idx), 5);
        reset_n = 1'b0;
        step();
        checkResetState("t6_reset");
        reset_n = 1'b1;
        step();
        sendWords(32'h2000, 16, st);
        sendDone(1'b0, 0, st);
        drainBatch(32'h2000, 16, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
